// File: rtl/mem_port_arbiter.sv
// Shares one single-ported instruction/data memory between the IF and MEM stages.
// One access is in flight at a time; DM wins ties, but a bounded DM streak forces an IF grant.
module mem_port_arbiter #(
  parameter int AW            = 16,
  parameter int DW            = 16,
  parameter int MEM_LAT       = 1,
  parameter int MAX_DM_STREAK = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  input  logic          if_flush,
  output logic          if_ack,
  output logic [DW-1:0] if_rdata,
  output logic          if_stall,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic          dm_ack,
  output logic [DW-1:0] dm_rdata,
  output logic          dm_stall,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);
  localparam int SW = (MAX_DM_STREAK < 1) ? 1 : $clog2(MAX_DM_STREAK + 1);
  localparam int CW = (MEM_LAT < 2) ? 1 : $clog2(MEM_LAT);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DM_STREAK);
  localparam logic [CW-1:0] LAT_LAST   = CW'((MEM_LAT < 2) ? 0 : MEM_LAT - 2);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t state, state_nxt;

  logic          own_dm, we_q, flush_q;
  logic [SW-1:0] streak;
  logic [CW-1:0] lat_cnt;
  logic          if_cand, dm_cand, force_if, grant_if, grant_dm, rd_done;

  // A requester whose ack is showing this cycle is not re-granted until the next IDLE look.
  always_comb begin
    if_cand  = if_req & ~if_flush & ~if_ack & ~dm_ack;
    dm_cand  = dm_req & ~if_ack & ~dm_ack;
    force_if = (MAX_DM_STREAK != 0) && (streak == STREAK_MAX);
    grant_dm = (state == IDLE) & dm_cand & ~(if_cand & force_if);
    grant_if = (state == IDLE) & if_cand & ~grant_dm;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_if | grant_dm) state_nxt = ISSUE;
      ISSUE:   state_nxt = (we_q || MEM_LAT == 1) ? RESP : WAIT;
      WAIT:    if (lat_cnt == LAT_LAST) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mem_en   = (state == ISSUE) & ~rst;
    mem_we   = mem_en & we_q;
    rd_done  = (state == RESP) & ~we_q;
    if_stall = if_req & ~if_ack;
    dm_stall = dm_req & ~dm_ack;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      own_dm    <= 1'b0;
      we_q      <= 1'b0;
      flush_q   <= 1'b0;
      streak    <= '0;
      lat_cnt   <= '0;
      if_ack    <= 1'b0;
      dm_ack    <= 1'b0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      if_ack <= 1'b0;
      dm_ack <= 1'b0;
      if (grant_dm) begin
        own_dm    <= 1'b1;
        we_q      <= dm_we;
        mem_addr  <= dm_addr;
        mem_wdata <= dm_wdata;
        if (!if_cand)                 streak <= '0;
        else if (streak != STREAK_MAX) streak <= streak + SW'(1);
      end else if (grant_if) begin
        own_dm   <= 1'b0;
        we_q     <= 1'b0;
        mem_addr <= if_addr;
        streak   <= '0;
      end
      if (state == IDLE)
        flush_q <= 1'b0;
      else if (!own_dm && if_flush && (state == ISSUE || state == WAIT))
        flush_q <= 1'b1;
      lat_cnt <= (state == WAIT) ? lat_cnt + CW'(1) : '0;
      // Stores complete at issue and ack during RESP; loads ack once the data is captured.
      if (state == ISSUE && we_q) dm_ack <= 1'b1;
      if (rd_done) begin
        if (own_dm) begin
          dm_rdata <= mem_rdata;
          dm_ack   <= 1'b1;
        end else if (!flush_q && !if_flush) begin
          if_rdata <= mem_rdata;
          if_ack   <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: instance 0 uses MEM_LAT=1/MAX_DM_STREAK=4,
// instance 1 uses MEM_LAT=3/MAX_DM_STREAK=0; a small latency-accurate memory model feeds each.
module tb_mem_port_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        if_req [2];
  logic [15:0] if_addr [2];
  logic        if_flush [2];
  logic        if_ack [2];
  logic [15:0] if_rdata [2];
  logic        if_stall [2];
  logic        dm_req [2];
  logic        dm_we [2];
  logic [15:0] dm_addr [2];
  logic [15:0] dm_wdata [2];
  logic        dm_ack [2];
  logic [15:0] dm_rdata [2];
  logic        dm_stall [2];
  logic        mem_en [2];
  logic        mem_we [2];
  logic [15:0] mem_addr [2];
  logic [15:0] mem_wdata [2];
  logic [15:0] mem_rdata [2];

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  function automatic logic [15:0] rd_val(input logic [15:0] a);
    case (a)
      16'h0010: rd_val = 16'hA5A5;
      16'h0040: rd_val = 16'h4040;
      default:  rd_val = {a[7:0], ~a[7:0]};
    endcase
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 1 : 3;
    localparam int MS  = (g == 0) ? 4 : 0;

    mem_port_arbiter #(.AW(16), .DW(16), .MEM_LAT(LAT), .MAX_DM_STREAK(MS)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req[g]), .if_addr(if_addr[g]), .if_flush(if_flush[g]),
      .if_ack(if_ack[g]), .if_rdata(if_rdata[g]), .if_stall(if_stall[g]),
      .dm_req(dm_req[g]), .dm_we(dm_we[g]), .dm_addr(dm_addr[g]), .dm_wdata(dm_wdata[g]),
      .dm_ack(dm_ack[g]), .dm_rdata(dm_rdata[g]), .dm_stall(dm_stall[g]),
      .mem_en(mem_en[g]), .mem_we(mem_we[g]), .mem_addr(mem_addr[g]),
      .mem_wdata(mem_wdata[g]), .mem_rdata(mem_rdata[g])
    );

    // Read data is only valid exactly LAT cycles after the strobe; garbage otherwise.
    logic [2:0]  vpipe = '0;
    logic [15:0] apipe [3];
    always @(posedge clk) begin
      vpipe    <= {vpipe[1:0], mem_en[g] & ~mem_we[g]};
      apipe[0] <= mem_addr[g];
      apipe[1] <= apipe[0];
      apipe[2] <= apipe[1];
    end
    assign mem_rdata[g] = vpipe[LAT-1] ? rd_val(apipe[LAT-1]) : 16'hDEAD;

    logic        ifq = 1'b0, ifaq = 1'b0, dmq = 1'b0, dmaq = 1'b0, dmwe_q = 1'b0;
    logic [15:0] ifa_q = '0, dma_q = '0, dmw_q = '0;
    always @(negedge clk) begin
      ifq <= if_req[g];  ifaq <= if_ack[g]; ifa_q <= if_addr[g];
      dmq <= dm_req[g];  dmaq <= dm_ack[g]; dma_q <= dm_addr[g];
      dmw_q <= dm_wdata[g]; dmwe_q <= dm_we[g];
      if (if_req[g] && ifq && !ifaq)
        assert (if_addr[g] == ifa_q) else $error("protocol: if_addr moved while if_req held");
      if (dm_req[g] && dmq && !dmaq)
        assert ({dm_we[g], dm_addr[g], dm_wdata[g]} == {dmwe_q, dma_q, dmw_q})
          else $error("protocol: dm payload moved while dm_req held");
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in(input int g);
    if_req[g] = 1'b0; if_addr[g] = '0; if_flush[g] = 1'b0;
    dm_req[g] = 1'b0; dm_we[g] = 1'b0; dm_addr[g] = '0; dm_wdata[g] = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acks, grants, n, ifg, dmg;
    logic seq [6];
    logic exp_seq [6];
    exp_seq = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    for (int g = 0; g < 2; g++) idle_in(g);
    rst = 1'b1;
    repeat (2) cyc();
    #1;
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("rst_ctl%0d", g), {if_ack[g], dm_ack[g], mem_en[g], mem_we[g]}, 0);
      chk($sformatf("rst_rdata%0d", g), {if_rdata[g], dm_rdata[g]}, 0);
      chk($sformatf("rst_bus%0d", g), {mem_addr[g], mem_wdata[g]}, 0);
    end
    cyc(); rst = 1'b0;
    cyc();

    // Lone IF read on instance 0, held through ack and beyond
    if_req[0] = 1'b1; if_addr[0] = 16'h0010; #1;
    chk("t1_c0", {if_stall[0], mem_en[0]}, 2'b10);
    cyc(); #1;
    chk("t1_c1_strobe", {mem_en[0], mem_we[0]}, 2'b10);
    chk("t1_c1_addr", mem_addr[0], 16'h0010);
    cyc(); #1;
    chk("t1_c2", {mem_en[0], if_ack[0], if_stall[0]}, 3'b001);
    cyc(); #1;
    chk("t1_c3", {if_ack[0], if_stall[0]}, 2'b10);
    chk("t1_c3_rdata", if_rdata[0], 16'hA5A5);
    acks = 0; grants = 0;
    for (int c = 4; c <= 7; c++) begin
      cyc(); #1;
      acks += int'(if_ack[0]);
      grants += int'(mem_en[0]);
      if (c == 4) chk("t1_c4_quiet", {if_ack[0], mem_en[0]}, 2'b00);
      if (c == 5) chk("t1_c5_regrant", mem_en[0], 1'b1);
    end
    chk("t1_acks", acks, 1);
    chk("t1_grants", grants, 1);
    cyc(); if_req[0] = 1'b0;
    cyc(); cyc();

    // Lone DM store on instance 0
    dm_req[0] = 1'b1; dm_we[0] = 1'b1; dm_addr[0] = 16'h0100; dm_wdata[0] = 16'h1234; #1;
    chk("t2_c0", {dm_stall[0], mem_en[0]}, 2'b10);
    cyc(); #1;
    chk("t2_c1_strobe", {mem_en[0], mem_we[0]}, 2'b11);
    chk("t2_c1_bus", {mem_addr[0], mem_wdata[0]}, 32'h0100_1234);
    cyc(); #1;
    chk("t2_c2", {dm_ack[0], dm_stall[0], mem_en[0], mem_we[0], if_ack[0]}, 5'b10000);
    cyc(); dm_req[0] = 1'b0; #1;
    chk("t2_c3_hold", {mem_addr[0], mem_wdata[0]}, 32'h0100_1234);
    chk("t2_c3", {dm_ack[0], if_ack[0], mem_en[0]}, 3'b000);
    cyc(); cyc();

    // Both requesting with a streak limit of 4
    if_req[0] = 1'b1; if_addr[0] = 16'h0030;
    dm_req[0] = 1'b1; dm_we[0] = 1'b1; dm_addr[0] = 16'h0200; dm_wdata[0] = 16'h5555;
    n = 0;
    for (int c = 0; c < 60 && n < 6; c++) begin
      #1;
      if (mem_en[0]) begin seq[n] = mem_we[0]; n++; end
      cyc();
    end
    chk("t3_ngrants", n, 6);
    for (int i = 0; i < 6; i++) chk($sformatf("t3_grant%0d_is_dm", i), seq[i], exp_seq[i]);
    idle_in(0);
    repeat (6) cyc();

    // Both requesting with strict DM priority (instance 1)
    if_req[1] = 1'b1; if_addr[1] = 16'h0030;
    dm_req[1] = 1'b1; dm_we[1] = 1'b1; dm_addr[1] = 16'h0200; dm_wdata[1] = 16'h5555;
    ifg = 0; dmg = 0;
    for (int c = 0; c < 30; c++) begin
      #1;
      if (mem_en[1]) begin
        if (mem_we[1]) dmg++;
        else           ifg++;
      end
      cyc();
    end
    chk("t3b_if_grants", ifg, 0);
    chk("t3b_dm_grants", dmg, 10);
    dm_req[1] = 1'b0;
    acks = 0;
    for (int c = 30; c <= 35; c++) begin
      #1;
      acks += int'(if_ack[1]);
      if (c == 35) begin
        chk("t3b_if_ack", if_ack[1], 1'b1);
        chk("t3b_if_rdata", if_rdata[1], rd_val(16'h0030));
      end
      cyc();
    end
    if_req[1] = 1'b0;
    chk("t3b_if_acks", acks, 1);
    cyc(); cyc();

    // Flush in WAIT of an IF read (MEM_LAT=3)
    if_req[1] = 1'b1; if_addr[1] = 16'h0020;
    acks = 0;
    for (int c = 0; c <= 6; c++) begin
      if (c == 2) if_flush[1] = 1'b1;
      if (c == 3) begin if_flush[1] = 1'b0; if_req[1] = 1'b0; end
      #1;
      if (c == 1) chk("t4_issue", mem_en[1], 1'b1);
      acks += int'(if_ack[1]);
      cyc();
    end
    chk("t4_no_ack", acks, 0);
    chk("t4_rdata_kept", if_rdata[1], rd_val(16'h0030));
    if_req[1] = 1'b1; if_addr[1] = 16'h0040;
    acks = 0;
    for (int c = 0; c <= 5; c++) begin
      #1;
      acks += int'(if_ack[1]);
      if (c == 5) begin
        chk("t4_next_ack", if_ack[1], 1'b1);
        chk("t4_next_rdata", if_rdata[1], 16'h4040);
      end
      cyc();
    end
    if_req[1] = 1'b0;
    chk("t4_next_acks", acks, 1);
    cyc(); cyc();

    // Reset during ISSUE of a DM store, then a lone DM load
    dm_req[1] = 1'b1; dm_we[1] = 1'b1; dm_addr[1] = 16'h0300; dm_wdata[1] = 16'hBEEF;
    cyc(); rst = 1'b1; #1;
    chk("t5_gate", {mem_en[1], mem_we[1], dm_ack[1]}, 3'b000);
    cyc(); rst = 1'b0; dm_req[1] = 1'b0; #1;
    chk("t5_ctl", {if_ack[1], dm_ack[1], mem_en[1], mem_we[1]}, 4'b0000);
    chk("t5_bus", {mem_addr[1], mem_wdata[1]}, 32'h0);
    chk("t5_rdata", {if_rdata[1], dm_rdata[1]}, 32'h0);
    cyc();
    dm_req[1] = 1'b1; dm_we[1] = 1'b0; dm_addr[1] = 16'h0050; dm_wdata[1] = 16'h0000;
    acks = 0;
    for (int c = 0; c <= 5; c++) begin
      #1;
      acks += int'(dm_ack[1]);
      if (c == 1) chk("t5_load_issue", {mem_en[1], mem_we[1], mem_addr[1]}, {2'b10, 16'h0050});
      if (c == 5) begin
        chk("t5_load_ack", dm_ack[1], 1'b1);
        chk("t5_load_rdata", dm_rdata[1], rd_val(16'h0050));
      end
      cyc();
    end
    dm_req[1] = 1'b0;
    chk("t5_load_acks", acks, 1);
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
